io_supply_seq: RTL and testbench



---
 rtl/io_supply_pkg.sv | 23 ++
 rtl/io_sync2.sv | 28 ++
 rtl/io_supply_seq.sv | 167 ++++++++++++++++
 tb/tb_io_supply_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_supply_pkg.sv
// Shared types and defaults for the IO supply sequencer.
// State codes are visible on state_o, so their values are fixed.
package io_supply_pkg;

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_DEB  = 3'd1,
      ST_RAMP = 3'd2,
      ST_ON   = 3'd3,
      ST_DROP = 3'd4
   } seq_state_t;

   localparam int DEF_NUM_GRP  = 4;
   localparam int DEF_DEB_CYC  = 16;
   localparam int DEF_STEP_CYC = 8;
   localparam int DEF_CNT_W    = 8;

   // The group index must be able to reach NUM_GRP after the last enable.
   function automatic int idx_width(input int num_grp);
      return $clog2(num_grp + 1);
   endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser with asynchronous active-high reset.
// Shared with other pad-domain status inputs.
module io_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Metastability filter: first stage may go metastable, second resolves it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/io_supply_seq.sv
// IO supply-domain sequencer: debounces supply-good, releases pad retention,
// enables pad groups in timed steps and forces safe state on supply loss.
module io_supply_seq
   import io_supply_pkg::*;
#(
   parameter int NUM_GRP  = DEF_NUM_GRP,
   parameter int DEB_CYC  = DEF_DEB_CYC,
   parameter int STEP_CYC = DEF_STEP_CYC,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vsup_ok_i,
   input  logic               sw_en_i,
   input  logic               fault_clr_i,
   output logic [NUM_GRP-1:0] grp_en_o,
   output logic               pad_ret_o,
   output logic               io_ready_o,
   output logic               fault_o,
   output logic [2:0]         state_o
);

   localparam int                 IDX_W     = idx_width(NUM_GRP);
   localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_CYC - 1);
   localparam logic [IDX_W-1:0]   GRP_LAST  = IDX_W'(NUM_GRP - 1);
   localparam logic [NUM_GRP-1:0] GRP_ONE   = NUM_GRP'(1'b1);
   localparam logic [NUM_GRP-1:0] GRP_NONE  = {NUM_GRP{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [IDX_W-1:0]   IDX_ZERO  = {IDX_W{1'b0}};

   seq_state_t         state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [IDX_W-1:0]   idx_r;
   logic [NUM_GRP-1:0] grp_en_r;
   logic               pad_ret_r;
   logic               io_ready_r;
   logic               fault_r;
   logic               sync_ok_s;
   logic               drop_set_s;

   io_sync2 #(
      .WIDTH (1)
   ) u_vsup_sync (
      .clk (clk),
      .rst (rst),
      .d   (vsup_ok_i),
      .q   (sync_ok_s)
   );

   // Supply loss only counts once pads may be driven; it takes priority over release.
   assign drop_set_s = ((state_r == ST_RAMP) || (state_r == ST_ON)) && !sync_ok_s;

   // Sequencer FSM with registered pad controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_OFF;
         cnt_r      <= CNT_ZERO;
         idx_r      <= IDX_ZERO;
         grp_en_r   <= GRP_NONE;
         pad_ret_r  <= 1'b1;
         io_ready_r <= 1'b0;
      end else begin
         case (state_r)
            ST_OFF: begin
               cnt_r      <= CNT_ZERO;
               idx_r      <= IDX_ZERO;
               grp_en_r   <= GRP_NONE;
               pad_ret_r  <= 1'b1;
               io_ready_r <= 1'b0;
               if (sync_ok_s && sw_en_i && !fault_r) begin
                  state_r <= ST_DEB;
               end else begin
                  state_r <= ST_OFF;
               end
            end

            ST_DEB: begin
               if (!sync_ok_s || !sw_en_i) begin
                  state_r <= ST_OFF;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == DEB_LAST) begin
                  state_r   <= ST_RAMP;
                  cnt_r     <= CNT_ZERO;
                  idx_r     <= IDX_ZERO;
                  pad_ret_r <= 1'b0;
               end else begin
                  state_r <= ST_DEB;
                  cnt_r   <= cnt_r + CNT_W'(1'b1);
               end
            end

            ST_RAMP, ST_ON: begin
               if (drop_set_s) begin
                  state_r    <= ST_DROP;
                  cnt_r      <= CNT_ZERO;
                  idx_r      <= IDX_ZERO;
                  grp_en_r   <= GRP_NONE;
                  pad_ret_r  <= 1'b1;
                  io_ready_r <= 1'b0;
               end else if (!sw_en_i) begin
                  state_r    <= ST_OFF;
                  cnt_r      <= CNT_ZERO;
                  idx_r      <= IDX_ZERO;
                  grp_en_r   <= GRP_NONE;
                  pad_ret_r  <= 1'b1;
                  io_ready_r <= 1'b0;
               end else if (state_r == ST_ON) begin
                  state_r <= ST_ON;
               end else if (cnt_r == STEP_LAST) begin
                  // Step boundary: enable the next group; the last one completes power-up.
                  cnt_r    <= CNT_ZERO;
                  idx_r    <= idx_r + IDX_W'(1'b1);
                  grp_en_r <= grp_en_r | (GRP_ONE << idx_r);
                  if (idx_r == GRP_LAST) begin
                     state_r    <= ST_ON;
                     io_ready_r <= 1'b1;
                  end else begin
                     state_r <= ST_RAMP;
                  end
               end else begin
                  state_r <= ST_RAMP;
                  cnt_r   <= cnt_r + CNT_W'(1'b1);
               end
            end

            ST_DROP: begin
               state_r    <= ST_OFF;
               cnt_r      <= CNT_ZERO;
               idx_r      <= IDX_ZERO;
               grp_en_r   <= GRP_NONE;
               pad_ret_r  <= 1'b1;
               io_ready_r <= 1'b0;
            end

            default: begin
               state_r    <= ST_OFF;
               cnt_r      <= CNT_ZERO;
               idx_r      <= IDX_ZERO;
               grp_en_r   <= GRP_NONE;
               pad_ret_r  <= 1'b1;
               io_ready_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky supply-loss fault; a new loss beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_r <= 1'b0;
      end else if (drop_set_s) begin
         fault_r <= 1'b1;
      end else if (fault_clr_i) begin
         fault_r <= 1'b0;
      end else begin
         fault_r <= fault_r;
      end
   end

   assign grp_en_o   = grp_en_r;
   assign pad_ret_o  = pad_ret_r;
   assign io_ready_o = io_ready_r;
   assign fault_o    = fault_r;
   assign state_o    = state_r;

endmodule

// File: tb/tb_io_supply_seq.sv
// Directed self-checking bench for io_supply_seq with default parameters.
module tb_io_supply_seq;

   logic       clk;
   logic       rst;
   logic       vsup_ok;
   logic       sw_en;
   logic       fault_clr;
   logic [3:0] grp_en;
   logic       pad_ret;
   logic       io_ready;
   logic       fault;
   logic [2:0] state;

   int n_checks;
   int n_errors;
   int cyc;

   localparam logic [2:0] S_OFF  = 3'd0;
   localparam logic [2:0] S_DEB  = 3'd1;
   localparam logic [2:0] S_RAMP = 3'd2;
   localparam logic [2:0] S_ON   = 3'd3;
   localparam logic [2:0] S_DROP = 3'd4;

   io_supply_seq dut (
      .clk         (clk),
      .rst         (rst),
      .vsup_ok_i   (vsup_ok),
      .sw_en_i     (sw_en),
      .fault_clr_i (fault_clr),
      .grp_en_o    (grp_en),
      .pad_ret_o   (pad_ret),
      .io_ready_o  (io_ready),
      .fault_o     (fault),
      .state_o     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      vsup_ok   = 1'b0;
      sw_en     = 1'b0;
      fault_clr = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic check_safe(input string tag, input logic exp_fault);
      check_eq({tag, "_grp"}, 8'(grp_en), 8'h00);
      check_eq({tag, "_ret"}, 8'(pad_ret), 8'h01);
      check_eq({tag, "_rdy"}, 8'(io_ready), 8'h00);
      check_eq({tag, "_flt"}, 8'(fault), 8'(exp_fault));
   endtask

   // Raise supply and request at cycle 0, then run to the given cycle.
   task automatic power_up_to(input int target);
      sw_en   = 1'b1;
      vsup_ok = 1'b1;
      cyc     = 0;
      run_to(target);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;

      // Reset values
      do_reset();
      check_safe("rst", 1'b0);
      check_eq("rst_state", 8'(state), 8'(S_OFF));

      // Power-up timeline
      power_up_to(2);
      check_eq("pu_c2_state", 8'(state), 8'(S_OFF));
      run_to(3);
      check_eq("pu_c3_state", 8'(state), 8'(S_DEB));
      run_to(18);
      check_eq("pu_c18_state", 8'(state), 8'(S_DEB));
      check_eq("pu_c18_ret", 8'(pad_ret), 8'h01);
      run_to(19);
      check_eq("pu_c19_state", 8'(state), 8'(S_RAMP));
      check_eq("pu_c19_ret", 8'(pad_ret), 8'h00);
      run_to(26);
      check_eq("pu_c26_grp", 8'(grp_en), 8'h00);
      run_to(27);
      check_eq("pu_c27_grp", 8'(grp_en), 8'h01);
      run_to(35);
      check_eq("pu_c35_grp", 8'(grp_en), 8'h03);
      run_to(43);
      check_eq("pu_c43_grp", 8'(grp_en), 8'h07);
      run_to(50);
      check_eq("pu_c50_rdy", 8'(io_ready), 8'h00);
      run_to(51);
      check_eq("pu_c51_grp", 8'(grp_en), 8'h0f);
      check_eq("pu_c51_rdy", 8'(io_ready), 8'h01);
      check_eq("pu_c51_state", 8'(state), 8'(S_ON));

      // Supply loss in ON
      vsup_ok = 1'b0;
      cyc = 0;
      run_to(2);
      check_eq("loss_c2_grp", 8'(grp_en), 8'h0f);
      run_to(3);
      check_safe("loss_c3", 1'b1);
      check_eq("loss_c3_state", 8'(state), 8'(S_DROP));
      run_to(4);
      check_eq("loss_c4_state", 8'(state), 8'(S_OFF));
      vsup_ok = 1'b1;
      run_to(14);
      check_eq("loss_locked_state", 8'(state), 8'(S_OFF));
      check_eq("loss_locked_flt", 8'(fault), 8'h01);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check_eq("clr_flt", 8'(fault), 8'h00);
      check_eq("clr_state", 8'(state), 8'(S_OFF));
      tick();
      check_eq("rearm_state", 8'(state), 8'(S_DEB));

      // Debounce glitch: supply low for one cycle during DEB
      do_reset();
      power_up_to(10);
      vsup_ok = 1'b0;
      tick();
      vsup_ok = 1'b1;
      run_to(12);
      check_eq("gl_c12_state", 8'(state), 8'(S_DEB));
      run_to(13);
      check_eq("gl_c13_state", 8'(state), 8'(S_OFF));
      check_eq("gl_c13_flt", 8'(fault), 8'h00);
      run_to(14);
      check_eq("gl_c14_state", 8'(state), 8'(S_DEB));
      run_to(29);
      check_eq("gl_c29_state", 8'(state), 8'(S_DEB));
      run_to(30);
      check_eq("gl_c30_state", 8'(state), 8'(S_RAMP));

      // Supply loss and release in the same ON cycle: fault wins
      do_reset();
      power_up_to(51);
      vsup_ok = 1'b0;
      cyc = 0;
      run_to(2);
      sw_en = 1'b0;
      run_to(3);
      check_eq("sim_state", 8'(state), 8'(S_DROP));
      check_safe("sim", 1'b1);

      // Clear coinciding with a new loss: the set wins
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      check_eq("sim_clr_flt", 8'(fault), 8'h00);
      power_up_to(51);
      check_eq("clrdrop_on", 8'(state), 8'(S_ON));
      vsup_ok = 1'b0;
      cyc = 0;
      run_to(2);
      fault_clr = 1'b1;
      run_to(3);
      fault_clr = 1'b0;
      check_eq("clrdrop_c3_flt", 8'(fault), 8'h01);
      run_to(4);
      check_eq("clrdrop_c4_flt", 8'(fault), 8'h01);

      // Async reset clears a sticky fault between edges
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_flt", 8'(fault), 8'h00);
      rst = 1'b0;
      tick();

      // Software release mid-RAMP
      do_reset();
      power_up_to(35);
      check_eq("mr_c35_grp", 8'(grp_en), 8'h03);
      sw_en = 1'b0;
      run_to(36);
      check_safe("mr_c36", 1'b0);
      check_eq("mr_c36_state", 8'(state), 8'(S_OFF));

      // Async reset in ON, between edges
      do_reset();
      power_up_to(51);
      check_eq("aon_rdy", 8'(io_ready), 8'h01);
      #2;
      rst = 1'b1;
      #1;
      check_safe("aon", 1'b0);
      check_eq("aon_state", 8'(state), 8'(S_OFF));
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
